// File: rtl/acc_requant_fifo.sv
// Requantizes final accumulator column vectors (scale, round-half-up shift, zero point,
// saturate) and queues packed results. Optional ReLU: define REQUANT_RELU_EN.

module acc_requant_lane #(
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        cap,
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [SCALE_WIDTH-1:0]      scale,
  input  logic [5:0]                  sh,
  input  logic signed [OUT_WIDTH-1:0] zp,
  input  logic                        relu,
  output logic signed [OUT_WIDTH-1:0] q,
  output logic                        sat
);
  localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
  // wide enough for the 2^62 rounding term and any shift up to 63
  localparam int RW = (PW + 1 > 65) ? PW + 1 : 65;
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] rnd, sum, r, v;
  logic signed [OUT_WIDTH-1:0] qs;

  always_ff @(posedge clk)
    if (cap) prod <= PW'(acc) * PW'($signed({1'b0, scale}));

  always_comb begin
    rnd = (sh == 6'd0) ? '0 : (RW'(1) << (sh - 6'd1));
    sum = RW'(prod) + rnd;
    r   = sum >>> sh;
    v   = r + RW'(zp);
    sat = (v > MAXV) || (v < MINV);
    if (v > MAXV)      qs = OUT_WIDTH'(MAXV);
    else if (v < MINV) qs = OUT_WIDTH'(MINV);
    else               qs = v[OUT_WIDTH-1:0];
  end

`ifdef REQUANT_RELU_EN
  assign q = (relu && (qs < zp)) ? zp : qs;
`else
  logic unused_relu;
  assign unused_relu = relu;
  assign q = qs;
`endif
endmodule

module acc_requant_fifo #(
  parameter int TILE_SIZE   = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic signed [ACC_WIDTH-1:0]     in_vec [TILE_SIZE-1:0],
  input  logic [SCALE_WIDTH-1:0]          cfg_scale,
  input  logic [5:0]                      cfg_shift,
  input  logic [OUT_WIDTH-1:0]            cfg_zp,
  input  logic                            cfg_relu,
  input  logic                            ovf_clr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_SIZE*OUT_WIDTH-1:0]  out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            sat_flag
);
  localparam int STAGES = 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic                              cap;
  logic [STAGES:1]                   vld_q;
  logic [STAGES:0]                   vld_pipe;
  logic [5:0]                        sh_q;
  logic signed [OUT_WIDTH-1:0]       zp_q;
  logic                              relu_q;
  logic [TILE_SIZE-1:0][OUT_WIDTH-1:0] lane_q;
  logic [TILE_SIZE-1:0]              lane_sat;
  logic [TILE_SIZE*OUT_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]                     wptr, rptr;
  logic                              push_req, push_ok, pop, full;

  // partial sums and clear pulses (in_last=0) never enter the pipe
  assign cap      = in_valid & in_last;
  assign vld_pipe = {vld_q, cap};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];

  // config travels with the data so it may change every cycle
  always_ff @(posedge clk)
    if (cap) begin
      sh_q   <= cfg_shift;
      zp_q   <= $signed(cfg_zp);
      relu_q <= cfg_relu;
    end

  for (genvar j = 0; j < TILE_SIZE; j++) begin : g_lane
    acc_requant_lane #(
      .ACC_WIDTH(ACC_WIDTH), .SCALE_WIDTH(SCALE_WIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .clk(clk), .cap(cap), .acc(in_vec[j]), .scale(cfg_scale),
      .sh(sh_q), .zp(zp_q), .relu(relu_q),
      .q(lane_q[j]), .sat(lane_sat[j])
    );
  end

  assign full      = fifo_count == CW'(FIFO_DEPTH);
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign push_req  = vld_pipe[STAGES];
  assign push_ok   = push_req & (~full | pop);
  assign out_data  = mem[rptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= lane_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // a drop in the same cycle as ovf_clr keeps the flag set
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
      sat_flag <= push_ok & (|lane_sat);
    end
endmodule

// File: tb/tb_acc_requant_fifo.sv
// Directed bench for acc_requant_fifo; expected values are hand-computed.

module tb_acc_requant_fifo;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_last;
  logic signed [31:0] in_vec [3:0];
  logic [15:0]       cfg_scale;
  logic [5:0]        cfg_shift;
  logic [7:0]        cfg_zp;
  logic              cfg_relu, ovf_clr, out_ready;
  logic              out_valid, overflow, sat_flag;
  logic [31:0]       out_data;
  logic [2:0]        fifo_count;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  acc_requant_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_vec(in_vec),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .sat_flag(sat_flag)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic set_vec(input int a, input int b, input int c, input int d);
    in_vec[0] = a; in_vec[1] = b; in_vec[2] = c; in_vec[3] = d;
  endtask

  // drives one final vector for a cycle; returns at the negedge after capture
  task automatic send(input int a, input int b, input int c, input int d);
    @(negedge clk);
    set_vec(a, b, c, d);
    in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic cfg(input int sc, input int sh, input int zp);
    cfg_scale = 16'(sc); cfg_shift = 6'(sh); cfg_zp = 8'(zp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; set_vec(0, 0, 0, 0);
    cfg(1, 0, 0); cfg_relu = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    rst_n = 1'b1;

    // pass-through, 2-cycle latency
    send(5, -3, 127, -128);
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'(pk(5, -3, 127, -128)));
    chk("t1_sat", 64'(sat_flag), 64'd0);
    chk("t1_count", 64'(fifo_count), 64'd1);
    pop1();
    chk("t1_count_pop", 64'(fifo_count), 64'd0);

    // saturation, sat_flag single pulse
    send(1000, -1000, 0, 128);
    @(negedge clk);
    chk("t2_data", 64'(out_data), 64'(pk(127, -128, 0, 127)));
    chk("t2_sat", 64'(sat_flag), 64'd1);
    pop1();
    chk("t2_sat_pulse", 64'(sat_flag), 64'd0);

    // round half up then zero point; cfg changes right after capture
    cfg(3, 1, 10);
    send(1, -1, 2, -3);
    cfg(1, 0, 0);
    @(negedge clk);
    chk("t3_data", 64'(out_data), 64'(pk(12, 9, 13, 6)));
    pop1();

    cfg(1, 2, 0);
    send(-6, 6, -2, 2);
    @(negedge clk);
    chk("t3b_data", 64'(out_data), 64'(pk(-1, 2, 0, 1)));
    pop1();

    // partial sums ignored
    cfg(1, 0, 0);
    @(negedge clk);
    set_vec(99, 99, 99, 99); in_valid = 1'b1; in_last = 1'b0;
    repeat (3) @(negedge clk);
    set_vec(7, 7, 7, 7); in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t4_count", 64'(fifo_count), 64'd1);
    chk("t4_data", 64'(out_data), 64'(pk(7, 7, 7, 7)));
    pop1();
    chk("t4_empty", 64'(fifo_count), 64'd0);

    // fill, overflow, drain order
    for (int k = 1; k <= 5; k++) send(k, k, k, k);
    @(negedge clk);
    chk("t5_count", 64'(fifo_count), 64'd4);
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk("t5_sat_drop", 64'(sat_flag), 64'd0);
    @(negedge clk);
    chk("t5_stable", 64'(out_data), 64'(pk(1, 1, 1, 1)));
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t5_drain%0d", k), 64'(out_data), 64'(pk(k, k, k, k)));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("t5_drained", 64'(fifo_count), 64'd0);
    chk("t5_drained_valid", 64'(out_valid), 64'd0);
    chk("t5_ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 64'(overflow), 64'd0);

    // full + push + pop in the same cycle
    for (int k = 1; k <= 4; k++) send(k, k, k, k);
    @(negedge clk);
    chk("t6_full", 64'(fifo_count), 64'd4);
    send(9, 9, 9, 9);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_count", 64'(fifo_count), 64'd4);
    chk("t6_no_ovf", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    chk("t6_head2", 64'(out_data), 64'(pk(2, 2, 2, 2)));
    repeat (3) @(negedge clk);
    chk("t6_tail9", 64'(out_data), 64'(pk(9, 9, 9, 9)));
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_empty", 64'(fifo_count), 64'd0);

    // drop concurrent with ovf_clr keeps overflow set
    for (int k = 1; k <= 4; k++) send(k, k, k, k);
    send(8, 8, 8, 8);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t7_ovf_wins", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // quantized-domain ReLU
    cfg(1, 0, -5); cfg_relu = 1'b1;
    send(-20, 3, 0, -1);
    cfg_relu = 1'b0;
    @(negedge clk);
`ifdef REQUANT_RELU_EN
    chk("t8_relu", 64'(out_data), 64'(pk(-5, -2, -5, -5)));
`else
    chk("t8_relu", 64'(out_data), 64'(pk(-25, -2, -5, -6)));
`endif
    pop1();

    // reset mid-stream flushes FIFO and in-flight vector
    cfg(1, 0, 0);
    send(4, 4, 4, 4);
    @(negedge clk);
    chk("t9_pre", 64'(fifo_count), 64'd1);
    send(6, 6, 6, 6);
    rst_n = 1'b0;
    #1;
    chk("t9_rst_valid", 64'(out_valid), 64'd0);
    chk("t9_rst_count", 64'(fifo_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t9_flushed", 64'(out_valid), 64'd0);
    chk("t9_flushed_cnt", 64'(fifo_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
